// File: rtl/lfsr_pkg.sv
// Shared definitions for the 89-bit Fibonacci PRBS (taps 0/51) generator and checker.
// Holds the LFSR geometry and the checker's lock-state encoding.
package lfsr_pkg;

    localparam int LFSR_WIDTH = 89;
    localparam int LFSR_TAP   = 51;

    localparam int DEF_LOCK_CNT  = 32;
    localparam int DEF_LOSS_ERRS = 8;
    localparam int DEF_WINDOW    = 256;
    localparam int DEF_CNT_W     = 32;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/lfsr_prbs_checker_if.sv
// Stream and status bundle between a PRBS source and the checker.
// The source side drives the serial bit and qualifiers; the checker returns lock and error status.
interface lfsr_prbs_checker_if #(
    parameter int CNT_W = 32
);

    logic             enable;
    logic             inBit;
    logic             clear;
    logic             locked;
    logic             errPulse;
    logic [CNT_W-1:0] errorCount;
    logic [CNT_W-1:0] bitCount;
    logic             zeroSeq;

    modport master (
        output enable, inBit, clear,
        input  locked, errPulse, errorCount, bitCount, zeroSeq
    );

    modport slave (
        input  enable, inBit, clear,
        output locked, errPulse, errorCount, bitCount, zeroSeq
    );

endinterface

// File: rtl/lfsr_prbs_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising receive checker for the Fibonacci PRBS: fills history, verifies predictions,
// then flywheels on its own prediction while counting errors and watching a loss-of-lock window.
module lfsr_prbs_checker
    import lfsr_pkg::*;
#(
    parameter int WIDTH     = LFSR_WIDTH,
    parameter int TAP       = LFSR_TAP,
    parameter int LOCK_CNT  = DEF_LOCK_CNT,
    parameter int LOSS_ERRS = DEF_LOSS_ERRS,
    parameter int WINDOW    = DEF_WINDOW,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    lfsr_prbs_checker_if.slave   bus
);

    localparam int FILL_W  = $clog2(WIDTH);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WINDOW);
    localparam int ERR_W   = $clog2(LOSS_ERRS + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
    localparam logic [ERR_W-1:0]   ERR_LIMIT  = ERR_W'(LOSS_ERRS);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     sr_q, sr_d;
    logic [FILL_W-1:0]    fill_cnt_q, fill_cnt_d;
    logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
    logic [WIN_W-1:0]     win_bits_q, win_bits_d;
    logic [ERR_W-1:0]     win_err_q, win_err_d;
    logic                 err_pulse_q, err_pulse_d;
    logic                 zero_seq_q, zero_seq_d;

    logic                 pred;
    logic                 mismatch;
    logic [ERR_W-1:0]     win_sum;
    logic                 bit_inc;
    logic                 err_inc;

    assign pred     = sr_q[0] ^ sr_q[TAP];
    assign mismatch = bus.inBit ^ pred;

    // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_cnt_d  = fill_cnt_q;
        match_cnt_d = match_cnt_q;
        win_bits_d  = win_bits_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        win_sum     = win_err_q;
        bit_inc     = 1'b0;
        err_inc     = 1'b0;

        if (bus.enable) begin
            unique case (state_q)
                FILL: begin
                    sr_d = {bus.inBit, sr_q[WIDTH-1:1]};
                    if (fill_cnt_q == FILL_LAST) begin
                        state_d     = VERIFY;
                        fill_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                    end
                end

                VERIFY: begin
                    sr_d = {bus.inBit, sr_q[WIDTH-1:1]};
                    if (!mismatch) begin
                        if (match_cnt_q == MATCH_LAST) begin
                            state_d    = LOCKED;
                            win_bits_d = '0;
                            win_err_d  = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d    = FILL;
                        fill_cnt_d = '0;
                    end
                end

                LOCKED: begin
                    // Flywheel on the prediction so a corrupted bit cannot poison later predictions.
                    sr_d        = {pred, sr_q[WIDTH-1:1]};
                    bit_inc     = 1'b1;
                    err_inc     = mismatch;
                    err_pulse_d = mismatch;
                    if (win_bits_q == WIN_LAST) begin
                        win_bits_d = '0;
                        win_sum    = ERR_W'(mismatch);
                    end else begin
                        win_bits_d = win_bits_q + 1'b1;
                        win_sum    = win_err_q + ERR_W'(mismatch);
                    end
                    win_err_d = win_sum;
                    if (win_sum >= ERR_LIMIT) begin
                        state_d    = FILL;
                        fill_cnt_d = '0;
                        win_err_d  = '0;
                    end
                end

                default: begin
                    state_d    = FILL;
                    fill_cnt_d = '0;
                end
            endcase
        end

        // Registered alongside locked so both change on the same edge.
        zero_seq_d = (state_d == LOCKED) && (sr_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            sr_q        <= '0;
            fill_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_bits_q  <= '0;
            win_err_q   <= '0;
            err_pulse_q <= 1'b0;
            zero_seq_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_cnt_q  <= fill_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_bits_q  <= win_bits_d;
            win_err_q   <= win_err_d;
            err_pulse_q <= err_pulse_d;
            zero_seq_q  <= zero_seq_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .clr   (bus.clear),
        .q     (bus.errorCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bit_inc),
        .clr   (bus.clear),
        .q     (bus.bitCount)
    );

    assign bus.locked   = (state_q == LOCKED);
    assign bus.errPulse = err_pulse_q;
    assign bus.zeroSeq  = zero_seq_q;

endmodule
